fp_aligner: RTL and testbench

Pre-adder operand alignment stage of the floating-point adder. It accepts two packed IEEE-754-style operands and unpacks them. It orders the operands by magnitude and right-shifts the smaller mantissa by the exponent difference, one bit per cycle, accumulating a sticky bit. It then presents the common exponent and both aligned mantissas to the mantissa adder, whose result goes to the downstream normalizer. It is the inverse operation of normalization: shift right with an exponent equalisation, instead of shift left with an exponent decrement.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_unpacker.sv | 28 ++
 rtl/fp_aligner.sv | 133 +++++++++++++
 tb/tb_fp_aligner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder datapath.
// Default widths describe IEEE-754 single precision.
package fp_pkg;

  localparam int EXP_WIDTH      = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int FLUSH_LIMIT    = MANTISSA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } align_state_t;

  typedef struct packed {
    logic                      sign;
    logic [EXP_WIDTH-1:0]      eff_exp;
    logic [MANTISSA_WIDTH:0]   mant;
  } fp_unpacked_t;

  // Shift distance at or beyond which every mantissa bit, plus the guard
  // position, is gone and the small operand collapses into the sticky bit.
  function automatic int flush_limit(input int mantissa_width);
    return mantissa_width + 2;
  endfunction

endpackage

// File: rtl/fp_unpacker.sv
// Splits a packed operand into sign, effective exponent and mantissa with
// the hidden bit restored; flags Inf/NaN exponents.
module fp_unpacker #(
  parameter int EXP_WIDTH      = fp_pkg::EXP_WIDTH,
  parameter int MANTISSA_WIDTH = fp_pkg::MANTISSA_WIDTH
) (
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] op_in,
  output logic                              sign_out,
  output logic [EXP_WIDTH-1:0]              eff_exp_out,
  output logic [MANTISSA_WIDTH:0]           mant_out,
  output logic                              special_out
);

  logic [EXP_WIDTH-1:0]      exp_field;
  logic [MANTISSA_WIDTH-1:0] frac_field;
  logic                      exp_zero;

  assign sign_out   = op_in[EXP_WIDTH+MANTISSA_WIDTH];
  assign exp_field  = op_in[EXP_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
  assign frac_field = op_in[MANTISSA_WIDTH-1:0];
  assign exp_zero   = (exp_field == '0);

  // Subnormals share the scale of exponent 1 but carry no hidden bit.
  assign eff_exp_out = exp_zero ? EXP_WIDTH'(1) : exp_field;
  assign mant_out    = {~exp_zero, frac_field};
  assign special_out = &exp_field;

endmodule

// File: rtl/fp_aligner.sv
// Operand alignment ahead of the mantissa adder: orders the operands by
// magnitude and shifts the smaller mantissa right one bit per cycle.
module fp_aligner #(
  parameter int EXP_WIDTH      = fp_pkg::EXP_WIDTH,
  parameter int MANTISSA_WIDTH = fp_pkg::MANTISSA_WIDTH
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
  input  logic                              in_valid_in,
  output logic                              in_ready_out,
  output logic                              out_valid_out,
  input  logic                              out_ready_in,
  output logic [EXP_WIDTH-1:0]              exp_out,
  output logic [MANTISSA_WIDTH:0]           big_m_out,
  output logic [MANTISSA_WIDTH:0]           small_m_out,
  output logic                              big_sign_out,
  output logic                              small_sign_out,
  output logic                              sticky_out,
  output logic                              swap_out,
  output logic                              special_out
);

  import fp_pkg::*;

  localparam int CNT_W = $clog2(MANTISSA_WIDTH + 2);
  localparam logic [EXP_WIDTH-1:0] FLUSH_DIFF =
    EXP_WIDTH'(flush_limit(MANTISSA_WIDTH));

  logic                      a_sign, b_sign, a_special, b_special;
  logic [EXP_WIDTH-1:0]      a_eff_exp, b_eff_exp;
  logic [MANTISSA_WIDTH:0]   a_mant, b_mant;

  fp_unpacker #(.EXP_WIDTH(EXP_WIDTH), .MANTISSA_WIDTH(MANTISSA_WIDTH)) u_unpack_a (
    .op_in(a_in), .sign_out(a_sign), .eff_exp_out(a_eff_exp),
    .mant_out(a_mant), .special_out(a_special)
  );

  fp_unpacker #(.EXP_WIDTH(EXP_WIDTH), .MANTISSA_WIDTH(MANTISSA_WIDTH)) u_unpack_b (
    .op_in(b_in), .sign_out(b_sign), .eff_exp_out(b_eff_exp),
    .mant_out(b_mant), .special_out(b_special)
  );

  logic                    b_bigger, any_special;
  logic                    big_sign, small_sign;
  logic [EXP_WIDTH-1:0]    big_exp, small_exp, diff;
  logic [MANTISSA_WIDTH:0] big_mant, small_mant;

  // Ordering uses the stored fraction, not the mantissa; ties leave a as big.
  assign b_bigger    = {b_eff_exp, b_mant[MANTISSA_WIDTH-1:0]} >
                       {a_eff_exp, a_mant[MANTISSA_WIDTH-1:0]};
  assign any_special = a_special | b_special;
  assign big_sign    = b_bigger ? b_sign    : a_sign;
  assign small_sign  = b_bigger ? a_sign    : b_sign;
  assign big_exp     = b_bigger ? b_eff_exp : a_eff_exp;
  assign small_exp   = b_bigger ? a_eff_exp : b_eff_exp;
  assign big_mant    = b_bigger ? b_mant    : a_mant;
  assign small_mant  = b_bigger ? a_mant    : b_mant;
  assign diff        = big_exp - small_exp;

  align_state_t     state;
  logic [CNT_W-1:0] count;

  assign in_ready_out = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      count          <= '0;
      out_valid_out  <= 1'b0;
      exp_out        <= '0;
      big_m_out      <= '0;
      small_m_out    <= '0;
      big_sign_out   <= 1'b0;
      small_sign_out <= 1'b0;
      sticky_out     <= 1'b0;
      swap_out       <= 1'b0;
      special_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_in) begin
            exp_out        <= big_exp;
            big_m_out      <= big_mant;
            big_sign_out   <= big_sign;
            small_sign_out <= small_sign;
            swap_out       <= b_bigger;
            special_out    <= any_special;
            sticky_out     <= 1'b0;
            count          <= '0;
            if (any_special || diff == '0) begin
              small_m_out   <= small_mant;
              out_valid_out <= 1'b1;
              state         <= HOLD;
            end else if (diff >= FLUSH_DIFF) begin
              small_m_out   <= '0;
              sticky_out    <= |small_mant;
              out_valid_out <= 1'b1;
              state         <= HOLD;
            end else begin
              small_m_out <= small_mant;
              count       <= CNT_W'(diff);
              state       <= SHIFT;
            end
          end
        end
        SHIFT: begin
          small_m_out <= small_m_out >> 1;
          sticky_out  <= sticky_out | small_m_out[0];
          count       <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            out_valid_out <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_in) begin
            out_valid_out <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          out_valid_out <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_aligner.sv
// Self-checking bench for fp_aligner: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_fp_aligner;
  import fp_pkg::*;

  localparam int EW = EXP_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int OW = 1 + EW + MW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [OW-1:0] a_in, b_in;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [EW-1:0] exp_out;
  logic [MW:0]   big_m, small_m;
  logic          big_sign, small_sign, sticky, swap, special;

  fp_aligner dut (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a_in), .b_in(b_in),
    .in_valid_in(in_valid), .in_ready_out(in_ready),
    .out_valid_out(out_valid), .out_ready_in(out_ready),
    .exp_out(exp_out), .big_m_out(big_m), .small_m_out(small_m),
    .big_sign_out(big_sign), .small_sign_out(small_sign),
    .sticky_out(sticky), .swap_out(swap), .special_out(special)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] exp;
    logic [MW:0]   big_m;
    logic [MW:0]   small_m;
    logic          big_sign;
    logic          small_sign;
    logic          sticky;
    logic          swap;
    logic          special;
    int            lat;
  } expect_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic fp_unpacked_t unpack(input logic [OW-1:0] x);
    fp_unpacked_t u;
    int e;
    e         = int'(x[OW-2:MW]);
    u.sign    = x[OW-1];
    u.eff_exp = (e == 0) ? EW'(1) : EW'(e);
    u.mant    = {(e != 0), x[MW-1:0]};
    return u;
  endfunction

  // Reference: magnitude key = eff_exp * 2^MW + frac; shift by plain division.
  function automatic expect_t model(input logic [OW-1:0] a, input logic [OW-1:0] b);
    fp_unpacked_t ua, ub, bg, sm;
    longint       ka, kb, sm_val, scale;
    int           d;
    expect_t      e;
    ua = unpack(a);
    ub = unpack(b);
    ka = longint'(ua.eff_exp) * (longint'(1) << MW) + longint'(a[MW-1:0]);
    kb = longint'(ub.eff_exp) * (longint'(1) << MW) + longint'(b[MW-1:0]);
    e.swap = (kb > ka);
    bg = e.swap ? ub : ua;
    sm = e.swap ? ua : ub;
    d  = int'(bg.eff_exp) - int'(sm.eff_exp);
    e.exp        = bg.eff_exp;
    e.big_m      = bg.mant;
    e.big_sign   = bg.sign;
    e.small_sign = sm.sign;
    e.special    = (a[OW-2:MW] == '1) || (b[OW-2:MW] == '1);
    sm_val       = longint'(sm.mant);
    if (e.special) begin
      e.small_m = sm.mant;
      e.sticky  = 1'b0;
      e.lat     = 1;
    end else if (d >= MW + 2) begin
      e.small_m = '0;
      e.sticky  = (sm_val != 0);
      e.lat     = 1;
    end else begin
      scale     = longint'(1) << d;
      e.small_m = (MW + 1)'(sm_val / scale);
      e.sticky  = (sm_val % scale) != 0;
      e.lat     = (d == 0) ? 1 : 1 + d;
    end
    return e;
  endfunction

  task automatic check_outputs(input expect_t e);
    check("exp_out",    32'(exp_out),    32'(e.exp));
    check("big_m",      32'(big_m),      32'(e.big_m));
    check("small_m",    32'(small_m),    32'(e.small_m));
    check("big_sign",   32'(big_sign),   32'(e.big_sign));
    check("small_sign", 32'(small_sign), 32'(e.small_sign));
    check("sticky",     32'(sticky),     32'(e.sticky));
    check("swap",       32'(swap),       32'(e.swap));
    check("special",    32'(special),    32'(e.special));
  endtask

  task automatic accept(input logic [OW-1:0] a, input logic [OW-1:0] b);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_txn(input logic [OW-1:0] a, input logic [OW-1:0] b, input int hold);
    expect_t e;
    int      lat;
    e = model(a, b);
    accept(a, b);
    wait_valid(lat);
    check("latency", 32'(lat), 32'(e.lat));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    check_outputs(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("valid_held", 32'(out_valid), 32'd1);
      check("in_ready_held", 32'(in_ready), 32'd0);
      check_outputs(e);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_hs", 32'(in_ready), 32'd1);
    check("valid_dropped", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    expect_t e;
    int      lat;
    logic [OW-1:0] ra, rb;
    int      ea, eb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #1;
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_exp",     32'(exp_out),   32'd0);
    check("rst_small_m", 32'(small_m),   32'd0);
    check("rst_flags",   32'({big_sign, small_sign, sticky, swap, special}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed cases from the plan
    run_txn(32'h3F80_0000, 32'h3F80_0000, 0);
    run_txn(32'h3F80_0000, 32'h3E80_0000, 0);
    run_txn(32'h3E80_0001, 32'h3F80_0000, 0);
    run_txn(32'h4E80_0000, 32'h3F80_0001, 0);
    run_txn(32'h3F80_0000, 32'h3E80_0000, 5);
    run_txn(32'h7F80_0000, 32'h3F80_0000, 1);
    run_txn(32'h0000_0003, 32'h0000_0005, 0);
    run_txn(32'hBF80_0000, 32'h3F7F_FFFF, 0);
    run_txn(32'h4C00_0001, 32'h3F80_0001, 0);

    // Input offered during the output handshake must be ignored
    e = model(32'h3F80_0000, 32'h3F80_0000);
    accept(32'h3F80_0000, 32'h3F80_0000);
    wait_valid(lat);
    check("latency_hs", 32'(lat), 32'(e.lat));
    a_in      = 32'h4100_0000;
    b_in      = 32'h3F80_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; out_ready = 1'b0; end
    @(negedge clk);
    check("hs_ignored_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("hs_still_idle", 32'(out_valid), 32'd0);
    check("hs_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a 20-bit shift aborts the operation
    accept(32'h4980_0000, 32'h3F80_0000);
    repeat (5) @(negedge clk);
    check("mid_shift_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid",   32'(out_valid), 32'd0);
    check("abort_exp",     32'(exp_out),   32'd0);
    check("abort_big_m",   32'(big_m),     32'd0);
    check("abort_small_m", 32'(small_m),   32'd0);
    check("abort_flags",   32'({big_sign, small_sign, sticky, swap, special}), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h3F80_0000, 32'h3F80_0000, 0);

    // Random operands with exponents clustered so all shift regimes occur
    for (int n = 0; n < 60; n++) begin
      ea = int'($urandom_range(0, 254));
      if ($urandom_range(0, 11) == 0) ea = 0;
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 0) eb = 0;
      if (eb > 254) eb = 254;
      if ($urandom_range(0, 15) == 0) eb = 255;
      ra = {1'($urandom), EW'(ea), MW'($urandom)};
      rb = {1'($urandom), EW'(eb), MW'($urandom)};
      if ($urandom_range(0, 7) == 0) rb[MW-1:0] = ra[MW-1:0];
      run_txn(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
